// File: rtl/addsub_32_seq_unit.sv
// Sequential add/subtract unit: one 16-bit carry-lookahead slice reused over
// DATA_W/16 cycles (low slice first), with the inter-slice carry held in a register.

module addsub_32_seq_unit_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       gp,
    output logic       gg
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        s    = p ^ c;
        gp   = &p;
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
endmodule

module addsub_32_seq_unit_cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    logic [3:0] gp;
    logic [3:0] gg;
    logic [4:0] c;

    // Lookahead carry unit over the four group propagate/generate pairs
    always_comb begin
        c[0] = cin;
        c[1] = gg[0] | (gp[0] & c[0]);
        c[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c[0]);
        c[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
             | (gp[2] & gp[1] & gp[0] & c[0]);
        c[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
             | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & c[0]);
        cout = c[4];
    end

    for (genvar k = 0; k < 4; k++) begin : g_grp
        addsub_32_seq_unit_cla4 u_cla4 (
            .a   (a[k*4 +: 4]),
            .b   (b[k*4 +: 4]),
            .cin (c[k]),
            .s   (s[k*4 +: 4]),
            .gp  (gp[k]),
            .gg  (gg[k])
        );
    end
endmodule

module addsub_32_seq_unit #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              overflow,
    output logic              zero,
    output logic              busy
);
    localparam int NS    = DATA_W / SLICE_W;
    localparam int IDX_W = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NS - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic               cy_q;
    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_c;
    logic [DATA_W-1:0]  res_next;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_comb begin
        sl_a     = '0;
        sl_b     = '0;
        res_next = result;
        for (int unsigned i = 0; i < NS; i++) begin
            if (idx == IDX_W'(i)) begin
                sl_a = a_q[i*SLICE_W +: SLICE_W];
                sl_b = b_q[i*SLICE_W +: SLICE_W];
                res_next[i*SLICE_W +: SLICE_W] = sl_s;
            end
        end
    end

    addsub_32_seq_unit_cla16 u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (cy_q),
        .s    (sl_s),
        .cout (sl_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (idx == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            cy_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q  <= a;
                    b_q  <= b ^ {DATA_W{sub}};
                    cy_q <= sub;
                    idx  <= '0;
                end
                CALC: begin
                    result <= res_next;
                    cy_q   <= sl_c;
                    idx    <= idx + IDX_W'(1);
                    // Flags use the slice just computed, not the stale result register
                    if (idx == LAST) begin
                        carry    <= sl_c;
                        zero     <= (res_next == '0);
                        overflow <= (a_q[DATA_W-1] == b_q[DATA_W-1]) &&
                                    (sl_s[SLICE_W-1] != a_q[DATA_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_32_seq_unit.sv
// Self-checking bench for addsub_32_seq_unit against a plain-arithmetic reference model.

module tb_addsub_32_seq_unit;
    localparam int DATA_W = 32;
    localparam int NS     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              overflow;
    logic              zero;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    addsub_32_seq_unit #(.DATA_W(DATA_W), .SLICE_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    // Returns {zero, overflow, carry, result} from integer arithmetic
    function automatic logic [DATA_W+2:0] model(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W-1:0] y,
                                                input logic s);
        logic [DATA_W:0]   full;
        logic [DATA_W-1:0] r;
        logic              ov;
        if (s) full = {1'b0, x} + {1'b0, ~y} + 33'd1;
        else   full = {1'b0, x} + {1'b0, y};
        r = full[DATA_W-1:0];
        if (s) ov = (x[DATA_W-1] != y[DATA_W-1]) && (r[DATA_W-1] != x[DATA_W-1]);
        else   ov = (x[DATA_W-1] == y[DATA_W-1]) && (r[DATA_W-1] != x[DATA_W-1]);
        return {(r == '0), ov, full[DATA_W], r};
    endfunction

    // Stimulus only: present one operation and wait (bounded) for out_valid
    task automatic run_op(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                          input logic s, output int lat, output logic timeout);
        a = x; b = y; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        timeout = !out_valid;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [DATA_W-1:0] x,
                            input logic [DATA_W-1:0] y, input logic s);
        int lat;
        logic to;
        logic [DATA_W+2:0] exp, got;
        exp = model(x, y, s);
        run_op(x, y, s, lat, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s timeout: out_valid never rose", name);
        end
        checks++;
        if (lat !== NS) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, NS);
        end
        got = {zero, overflow, carry, result};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s a=%h b=%h sub=%0b: got z/o/c/r=%h expected %h",
                     name, x, y, s, got, exp);
        end
        consume();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 32'h1; b = 32'h2; sub = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if ({out_valid, busy, carry, overflow, zero, result} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ov=%b busy=%b c=%b o=%b z=%b r=%h expected all 0",
                     out_valid, busy, carry, overflow, zero, result);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_directed();
        check_op("carry_across_slice", 32'h0000FFFF, 32'h00000001, 1'b0);
        check_op("signed_overflow",    32'h7FFFFFFF, 32'h00000001, 1'b0);
        check_op("sub_equal_zero",     32'h00000005, 32'h00000005, 1'b1);
        check_op("sub_borrow",         32'h00000000, 32'h00000001, 1'b1);
        check_op("sub_overflow",       32'h80000000, 32'h00000001, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            check_op("random", $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_hold();
        int lat;
        logic to;
        logic [DATA_W+2:0] exp;
        exp = model(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat, to);
        checks++;
        if (to) begin errors++; $display("FAIL hold_timeout: out_valid never rose"); end
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin a = 32'h12345678; b = 32'h1; sub = 1'b1; in_valid = 1'b1; end
            else in_valid = 1'b0;
            checks++;
            if ({out_valid, in_ready, zero, overflow, carry, result} !== {2'b10, exp}) begin
                errors++;
                $display("FAIL hold_stable cycle %0d: ov=%b ir=%b z/o/c/r=%h expected ov=1 ir=0 %h",
                         c, out_valid, in_ready, {zero, overflow, carry, result}, exp);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (result !== 32'hFFFFFFFE || carry !== 1'b1) begin
            errors++; $display("FAIL hold_final: r=%h c=%b expected fffffffe 1", result, carry);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: ov=%b ir=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        a = 32'hDEADBEEF; b = 32'h01010101; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, carry, overflow, zero, result} !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_state: ov=%b busy=%b c=%b o=%b z=%b r=%h ir=%b expected zeros, ir=1",
                     out_valid, busy, carry, overflow, zero, result, in_ready);
        end
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_mid_no_valid: out_valid rose after abandon, expected never");
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W+2:0] q[$];
        logic [DATA_W+2:0] got;
        int accepts = 0, outs = 0, last_acc = -1, cyc = 0;
        logic fire_in, fire_out;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1; out_ready = 1'b1;
        while ((accepts < 4 || q.size() != 0) && cyc < 60) begin
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                got = {zero, overflow, carry, result};
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious: result %h with nothing outstanding", got);
                end else begin
                    if (got !== q[0]) begin
                        errors++; $display("FAIL b2b_result %0d: got %h expected %h", outs, got, q[0]);
                    end
                    void'(q.pop_front());
                end
                outs++;
            end
            if (fire_in) begin
                q.push_back(model(a, b, sub));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc !== NS + 2) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles expected %0d", cyc - last_acc, NS + 2);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            @(posedge clk); #1;
            cyc++;
            if (fire_in) begin
                a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
                if (accepts >= 4) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (accepts != 4 || outs != 4) begin
            errors++; $display("FAIL b2b_count: accepts=%0d results=%0d expected 4 4", accepts, outs);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
